// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 inverting mux: steps the selects through channels 0..3,
// samples notY after a settle time and presents the assembled word with VALID/READY.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 2,
  parameter bit          CONT   = 1'b0
) (
  input  logic       CLK,
  input  logic       notRST,
  input  logic       START,
  input  logic       notY,
  input  logic       READY,
  output logic       A0,
  output logic       A1,
  output logic [3:0] Q,
  output logic       VALID,
  output logic       BUSY
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [3:0] SettleLoad = 4'(SETTLE);

  logic [1:0] state, stateNext;
  logic [1:0] ch, chNext, chInc;
  logic [3:0] settleCnt, settleNext;
  logic [3:0] shadow, shadowNext;
  logic [3:0] qNext;
  logic       validNext, busyNext, a0Next, a1Next;

  assign chInc = ch + 2'd1;

  always_comb begin
    stateNext  = state;
    chNext     = ch;
    settleNext = settleCnt;
    shadowNext = shadow;
    qNext      = Q;
    validNext  = VALID;
    busyNext   = BUSY;
    a0Next     = A0;
    a1Next     = A1;

    unique case (state)
      IDLE: begin
        busyNext = 1'b0;
        a0Next   = 1'b0;
        a1Next   = 1'b0;
        if (START) begin
          stateNext  = SCAN;
          chNext     = 2'd0;
          settleNext = SettleLoad;
          busyNext   = 1'b1;
        end
      end

      SCAN: begin
        if (settleCnt != 4'd0) begin
          settleNext = settleCnt - 4'd1;
        end else begin
          shadowNext[ch] = ~notY;
          if (ch != 2'd3) begin
            chNext     = chInc;
            settleNext = SettleLoad;
            // Channel index bit 0 drives A1, bit 1 drives A0 (mux wiring).
            a1Next     = chInc[0];
            a0Next     = chInc[1];
          end else begin
            qNext     = shadowNext;
            validNext = 1'b1;
            stateNext = HOLD;
            chNext    = 2'd0;
            a0Next    = 1'b0;
            a1Next    = 1'b0;
          end
        end
      end

      HOLD: begin
        if (VALID && READY) begin
          validNext = 1'b0;
          if (CONT || START) begin
            stateNext  = SCAN;
            chNext     = 2'd0;
            settleNext = SettleLoad;
          end else begin
            stateNext = IDLE;
            busyNext  = 1'b0;
          end
        end
      end

      default: begin
        stateNext = IDLE;
        chNext    = 2'd0;
        validNext = 1'b0;
        busyNext  = 1'b0;
        a0Next    = 1'b0;
        a1Next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge notRST) begin
    if (!notRST) begin
      state     <= IDLE;
      ch        <= 2'd0;
      settleCnt <= 4'd0;
      shadow    <= 4'd0;
      Q         <= 4'd0;
      VALID     <= 1'b0;
      BUSY      <= 1'b0;
      A0        <= 1'b0;
      A1        <= 1'b0;
    end else begin
      state     <= stateNext;
      ch        <= chNext;
      settleCnt <= settleNext;
      shadow    <= shadowNext;
      Q         <= qNext;
      VALID     <= validNext;
      BUSY      <= busyNext;
      A0        <= a0Next;
      A1        <= a1Next;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: three instances (SETTLE=2, SETTLE=2 with CONT, SETTLE=1)
// each driving a behavioural inverting 4:1 mux.
module tb_mux_scan_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic notRST;

  logic startA, readyA, notYA, a0A, a1A, validA, busyA;
  logic [3:0] qA, dA;
  logic startB, readyB, notYB, a0B, a1B, validB, busyB;
  logic [3:0] qB, dB;
  logic startC, readyC, notYC, a0C, a1C, validC, busyC;
  logic [3:0] qC, dC;

  // Mux model: channel i = {A0,A1}, output inverted.
  assign notYA = ~dA[{a0A, a1A}];
  assign notYB = ~dB[{a0B, a1B}];
  assign notYC = ~dC[{a0C, a1C}];

  mux_scan_ctrl #(.SETTLE(2), .CONT(1'b0)) dutA (
    .CLK(CLK), .notRST(notRST), .START(startA), .notY(notYA), .READY(readyA),
    .A0(a0A), .A1(a1A), .Q(qA), .VALID(validA), .BUSY(busyA)
  );

  mux_scan_ctrl #(.SETTLE(2), .CONT(1'b1)) dutB (
    .CLK(CLK), .notRST(notRST), .START(startB), .notY(notYB), .READY(readyB),
    .A0(a0B), .A1(a1B), .Q(qB), .VALID(validB), .BUSY(busyB)
  );

  mux_scan_ctrl #(.SETTLE(1), .CONT(1'b0)) dutC (
    .CLK(CLK), .notRST(notRST), .START(startC), .notY(notYC), .READY(readyC),
    .A0(a0C), .A1(a1C), .Q(qC), .VALID(validC), .BUSY(busyC)
  );

  typedef struct {
    logic [3:0] d;
    logic [3:0] expQ;
  } vec_t;

  vec_t vecs [6];
  int nVec  = 0;
  int nFail = 0;

  task automatic checkBit(input string name, input logic act, input logic exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic checkVec(input string name, input logic [3:0] act, input logic [3:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Called just after the START edge E; walks 12 edges checking select sequence,
  // then checks VALID/Q at E+12. A START pulse is injected at cycle startAt (-1 = none).
  task automatic followScanA(input logic [3:0] expQ, input string tag, input int startAt);
    logic [1:0] ch;
    for (int t = 0; t < 12; t++) begin
      ch = 2'(t / 3);
      checkVec({tag, " sel"}, {2'b00, a1A, a0A}, {2'b00, ch[0], ch[1]});
      checkBit({tag, " valid low"}, validA, 1'b0);
      checkBit({tag, " busy"}, busyA, 1'b1);
      startA = (t == startAt);
      tick();
    end
    startA = 1'b0;
    checkBit({tag, " valid rise"}, validA, 1'b1);
    checkVec({tag, " q"}, qA, expQ);
    checkVec({tag, " sel home"}, {2'b00, a1A, a0A}, 4'b0000);
  endtask

  task automatic scanA(input logic [3:0] d, input logic [3:0] expQ, input string tag);
    dA = d;
    startA = 1'b1;
    tick();
    startA = 1'b0;
    followScanA(expQ, tag, -1);
  endtask

  task automatic handshakeA(input logic [3:0] expQ, input string tag);
    readyA = 1'b1;
    tick();
    readyA = 1'b0;
    checkBit({tag, " hs valid"}, validA, 1'b0);
    checkBit({tag, " hs idle"}, busyA, 1'b0);
    checkVec({tag, " q kept"}, qA, expQ);
  endtask

  initial begin
    vecs[0] = '{d: 4'b0000, expQ: 4'b0000};
    vecs[1] = '{d: 4'b1111, expQ: 4'b1111};
    vecs[2] = '{d: 4'b0001, expQ: 4'b0001};
    vecs[3] = '{d: 4'b1000, expQ: 4'b1000};
    vecs[4] = '{d: 4'b0110, expQ: 4'b0110};
    vecs[5] = '{d: 4'b1001, expQ: 4'b1001};

    notRST = 1'b0;
    startA = 0; readyA = 0; dA = 4'b0000;
    startB = 0; readyB = 0; dB = 4'b0000;
    startC = 0; readyC = 0; dC = 4'b0000;
    #12;
    checkVec("reset q", qA, 4'b0000);
    checkBit("reset valid", validA, 1'b0);
    checkBit("reset busy", busyA, 1'b0);
    checkVec("reset sel", {2'b00, a1A, a0A}, 4'b0000);
    @(negedge CLK);
    notRST = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      scanA(vecs[i].d, vecs[i].expQ, $sformatf("vec%0d", i));
      handshakeA(vecs[i].expQ, $sformatf("vec%0d", i));
    end

    // Word 1010, then consumer stalls while inputs change.
    scanA(4'b1010, 4'b1010, "t2");
    dA = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkVec("t3 q stall", qA, 4'b1010);
      checkBit("t3 valid stall", validA, 1'b1);
    end
    handshakeA(4'b1010, "t3");

    // Asynchronous reset while channel 2 is selected.
    startA = 1'b1;
    tick();
    startA = 1'b0;
    repeat (7) tick();
    checkVec("t1 pre sel ch2", {2'b00, a1A, a0A}, 4'b0001);
    #2;
    notRST = 1'b0;
    #1;
    checkVec("t1 rst sel", {2'b00, a1A, a0A}, 4'b0000);
    checkBit("t1 rst valid", validA, 1'b0);
    checkVec("t1 rst q", qA, 4'b0000);
    checkBit("t1 rst busy", busyA, 1'b0);
    @(negedge CLK);
    notRST = 1'b1;
    tick();
    checkBit("t1 idle after rst", busyA, 1'b0);
    scanA(4'b1100, 4'b1100, "t1 rescan");
    handshakeA(4'b1100, "t1 rescan");

    // START during ch1 ignored; START with READY in HOLD chains a new scan.
    dA = 4'b0011;
    startA = 1'b1;
    tick();
    startA = 1'b0;
    followScanA(4'b0011, "t5a", 4);
    dA = 4'b1101;
    startA = 1'b1;
    readyA = 1'b1;
    tick();
    startA = 1'b0;
    readyA = 1'b0;
    checkBit("t5 hs valid", validA, 1'b0);
    followScanA(4'b1101, "t5b", -1);
    handshakeA(4'b1101, "t5b");
    repeat (2) tick();
    checkBit("t5 no extra valid", validA, 1'b0);

    // Continuous mode: back-to-back words with no idle gap.
    dB = 4'b1111;
    startB = 1'b1;
    tick();
    startB = 1'b0;
    repeat (11) tick();
    checkBit("t4 valid early", validB, 1'b0);
    tick();
    checkBit("t4 valid1", validB, 1'b1);
    checkVec("t4 q1", qB, 4'b1111);
    dB = 4'b0001;
    readyB = 1'b1;
    tick();
    readyB = 1'b0;
    checkBit("t4 hs valid", validB, 1'b0);
    checkBit("t4 no idle", busyB, 1'b1);
    checkVec("t4 sel ch0", {2'b00, a1B, a0B}, 4'b0000);
    repeat (11) tick();
    checkBit("t4 valid2 early", validB, 1'b0);
    tick();
    checkBit("t4 valid2", validB, 1'b1);
    checkVec("t4 q2", qB, 4'b0001);

    // SETTLE=1: D only shows the target in the 2nd cycle of each channel.
    dC = 4'b1001;
    startC = 1'b1;
    tick();
    startC = 1'b0;
    for (int t = 0; t < 8; t++) begin
      logic [1:0] ch;
      ch = 2'(t / 2);
      checkVec("t6 sel", {2'b00, a1C, a0C}, {2'b00, ch[0], ch[1]});
      checkBit("t6 valid low", validC, 1'b0);
      dC = (t % 2 == 1) ? 4'b0110 : 4'b1001;
      tick();
    end
    checkBit("t6 valid", validC, 1'b1);
    checkVec("t6 q", qC, 4'b0110);
    readyC = 1'b1;
    tick();
    readyC = 1'b0;
    checkBit("t6 hs valid", validC, 1'b0);
    checkBit("t6 hs idle", busyC, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
